// File: rtl/manchester_if.sv
// Serial line in, decoded byte stream and frame status out, for the Manchester receiver.
`timescale 1ns/1ps
interface manchester_if;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       cardet;
  logic       eof;
  logic       error;

  modport master (output rxd, input data, valid, cardet, eof, error);
  modport slave  (input rxd, output data, valid, cardet, eof, error);
endinterface

// File: rtl/manchester_receiver.sv
// Manchester line receiver: oversamples rxd, locks to the bit cell on the first
// falling edge out of idle, resyncs on mid-bit transitions and assembles bytes LSB first.
`timescale 1ns/1ps
module manchester_receiver #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 9600,
  parameter int OSR     = 16
) (
  input logic         clk,
  input logic         rst,
  manchester_if.slave mif
);
  localparam int DIV_RAW = CLKFREQ / (BAUD * OSR);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W    = $clog2(OSR);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_FIRST  = PH_W'(OSR / 4);
  localparam logic [PH_W-1:0]  PH_SECOND = PH_W'(3 * OSR / 4);
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0]  WIN_LO    = PH_W'(OSR / 2 - 2);
  localparam logic [PH_W-1:0]  WIN_HI    = PH_W'(OSR / 2 + 2);

  typedef enum logic [1:0] {IDLE, RECV, ERRWAIT} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             rxd_p0;
  logic             rxd_p1;
  logic             rx_last;
  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             half1;
  logic [PH_W-1:0]  hi_cnt;

  logic             edge_seen;
  logic             in_window;
  logic [PH_W-1:0]  phase_inc;
  logic [7:0]       shifted;

  assign edge_seen = (rxd_p1 != rx_last);
  assign in_window = (phase >= WIN_LO) && (phase <= WIN_HI);
  assign phase_inc = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  assign shifted   = {rxd_p1, shreg[7:1]};

  // Sample-tick divider
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= mif.rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      half1      <= 1'b0;
      rx_last    <= 1'b1;
      hi_cnt     <= '0;
      mif.data   <= 8'h00;
      mif.valid  <= 1'b0;
      mif.cardet <= 1'b0;
      mif.eof    <= 1'b0;
      mif.error  <= 1'b0;
    end else begin
      mif.valid <= 1'b0;
      mif.eof   <= 1'b0;
      mif.error <= 1'b0;
      if (tick) begin
        rx_last <= rxd_p1;
        case (state)
          IDLE: begin
            if (!rxd_p1) begin
              phase      <= '0;
              bit_idx    <= '0;
              state      <= RECV;
              mif.cardet <= 1'b1;
            end
          end
          RECV: begin
            // Only edges near mid-cell carry timing; boundary edges are ignored
            if (edge_seen && in_window) phase <= PH_MID;
            else                        phase <= phase_inc;
            if (phase == PH_FIRST) half1 <= rxd_p1;
            if (phase == PH_SECOND) begin
              if (half1 != rxd_p1) begin
                shreg   <= shifted;
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                  mif.data  <= shifted;
                  mif.valid <= 1'b1;
                end
              end else if (rxd_p1 && (bit_idx == 3'd0)) begin
                mif.eof    <= 1'b1;
                mif.cardet <= 1'b0;
                state      <= IDLE;
              end else begin
                mif.error  <= 1'b1;
                mif.cardet <= 1'b0;
                hi_cnt     <= '0;
                state      <= ERRWAIT;
              end
            end
          end
          ERRWAIT: begin
            // Wait for a full cell's worth of continuous idle before re-arming
            if (!rxd_p1) begin
              hi_cnt <= '0;
            end else if (hi_cnt == PH_LAST) begin
              hi_cnt <= '0;
              state  <= IDLE;
            end else begin
              hi_cnt <= hi_cnt + PH_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_manchester_receiver.sv
// Bench for manchester_receiver: directed frames against an expected-event queue.
`timescale 1ns/1ps
module tb_manchester_receiver;
  localparam int CLKFREQ = 3_200_000;
  localparam int BAUD    = 100_000;
  localparam int OSR     = 16;
  localparam int CELL    = 32;

  localparam int K_VALID = 0;
  localparam int K_EOF   = 1;
  localparam int K_ERR   = 2;
  localparam int K_OPT   = 3;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  manchester_if mif ();

  manchester_receiver #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .OSR(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  ev_t        evq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_valid = 0;
  int         n_eof = 0;
  int         n_err = 0;
  logic [7:0] data_exp = 8'h00;
  logic [7:0] last_byte = 8'h00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic b, int len);
    mif.rxd = ~b;
    cyc(len / 2);
    mif.rxd = b;
    cyc(len - len / 2);
  endtask

  task automatic send_byte(logic [7:0] v, int len_a, int len_b);
    for (int i = 0; i < 8; i++) send_bit(v[i], (i % 2 == 0) ? len_a : len_b);
  endtask

  task automatic idle(int cells);
    mif.rxd = 1'b1;
    cyc(cells * CELL);
  endtask

  task automatic expect_ev(int kind, logic [7:0] b);
    ev_t e;
    e.kind = kind;
    e.b    = b;
    evq.push_back(e);
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while (evq.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, evq.size(), 0);
    evq.delete();
  endtask

  task automatic clear_stats();
    n_valid = 0;
    n_eof   = 0;
    n_err   = 0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_data"},   mif.data,   8'h00);
    chk({tag, "_valid"},  mif.valid,  0);
    chk({tag, "_cardet"}, mif.cardet, 0);
    chk({tag, "_eof"},    mif.eof,    0);
    chk({tag, "_error"},  mif.error,  0);
  endtask

  // Every cycle: pulses must match the head of the expected-event queue,
  // data must hold the last expected byte, and pulses must never coincide.
  always @(negedge clk) begin
    int fk;
    if (rst) begin
      evq.delete();
      data_exp = 8'h00;
    end else begin
      fk = (evq.size() != 0) ? evq[0].kind : -1;
      if (mif.valid) begin
        n_valid++;
        last_byte = mif.data;
        chk("valid_pulse", mif.valid, (fk == K_VALID) ? 1 : 0);
        if (fk == K_VALID) begin
          chk("valid_data", mif.data, evq[0].b);
          chk("cardet_at_valid", mif.cardet, 1);
          data_exp = evq[0].b;
          void'(evq.pop_front());
        end
      end else begin
        chk("data_hold", mif.data, data_exp);
      end
      if (mif.eof) begin
        n_eof++;
        chk("eof_pulse", mif.eof, (fk == K_EOF || fk == K_OPT) ? 1 : 0);
        if (fk == K_EOF || fk == K_OPT) void'(evq.pop_front());
      end
      if (mif.error) begin
        n_err++;
        chk("error_pulse", mif.error, (fk == K_ERR || fk == K_OPT) ? 1 : 0);
        if (fk == K_ERR || fk == K_OPT) void'(evq.pop_front());
      end
      chk("valid_eof_excl", mif.valid & mif.eof, 0);
      chk("valid_error_excl", mif.valid & mif.error, 0);
    end
  end

  initial begin
    mif.rxd = 1'b1;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    chk_reset_outputs("reset");
    idle(2);

    // Clean two-byte frame followed by idle
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_VALID, 8'hA3);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'h55, CELL, CELL);
    chk("t1_cardet_mid", mif.cardet, 1);
    send_byte(8'hA3, CELL, CELL);
    idle(2);
    drain("t1_drain", 4 * CELL);
    chk("t1_cardet_end", mif.cardet, 0);
    chk("t1_last_byte", last_byte, 8'hA3);
    chk("t1_nvalid", n_valid, 2);
    chk("t1_neof", n_eof, 1);
    chk("t1_nerr", n_err, 0);
    idle(1);

    // Jittered cells (30/34 clks), then slow cells (36 clks) in the same frame
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_VALID, 8'h0F);
    expect_ev(K_VALID, 8'h5A);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'h55, 30, 34);
    send_byte(8'h0F, 30, 34);
    send_byte(8'h5A, 36, 36);
    idle(2);
    drain("t2_drain", 4 * CELL);
    chk("t2_last_byte", last_byte, 8'h5A);
    chk("t2_nvalid", n_valid, 3);
    chk("t2_nerr", n_err, 0);
    idle(1);

    // Line held high for a whole cell at bit index 3
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_ERR, 8'h00);
    send_byte(8'h55, CELL, CELL);
    send_bit(1'b1, CELL);
    send_bit(1'b1, CELL);
    send_bit(1'b1, CELL);
    idle(3);
    drain("t3_drain", 4 * CELL);
    chk("t3_data_kept", mif.data, 8'h55);
    chk("t3_nvalid", n_valid, 1);
    chk("t3_nerr", n_err, 1);
    chk("t3_cardet", mif.cardet, 0);
    clear_stats();
    expect_ev(K_VALID, 8'hC5);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'hC5, CELL, CELL);
    idle(2);
    drain("t3b_drain", 4 * CELL);
    chk("t3b_last_byte", last_byte, 8'hC5);
    chk("t3b_nerr", n_err, 0);
    idle(1);

    // Line held low for two cells, short idle, early falling edge, then real idle
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_ERR, 8'h00);
    send_byte(8'h55, CELL, CELL);
    send_bit(1'b1, CELL);
    send_bit(1'b0, CELL);
    mif.rxd = 1'b0;
    cyc(2 * CELL);
    mif.rxd = 1'b1;
    cyc(20);
    mif.rxd = 1'b0;
    cyc(4);
    idle(3);
    drain("t4_drain", 4 * CELL);
    chk("t4_nerr", n_err, 1);
    chk("t4_neof", n_eof, 0);
    chk("t4_data_kept", mif.data, 8'h55);
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'h55, CELL, CELL);
    idle(2);
    drain("t4b_drain", 4 * CELL);
    chk("t4b_nvalid", n_valid, 1);
    idle(1);

    // Reset pulse during bit 4 of the second byte
    clear_stats();
    expect_ev(K_VALID, 8'h55);
    send_byte(8'h55, CELL, CELL);
    for (int i = 0; i < 4; i++) send_bit(i < 2, CELL);
    mif.rxd = 1'b1;
    cyc(8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    idle(2);
    chk("t5_no_pulses", n_valid + n_eof + n_err, 1);
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_VALID, 8'h12);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'h55, CELL, CELL);
    send_byte(8'h12, CELL, CELL);
    idle(2);
    drain("t5_drain", 4 * CELL);
    chk("t5_last_byte", last_byte, 8'h12);
    chk("t5_nerr", n_err, 0);
    idle(1);

    // One-clock low glitch in idle
    clear_stats();
    expect_ev(K_OPT, 8'h00);
    mif.rxd = 1'b0;
    cyc(1);
    idle(3);
    if (evq.size() != 0 && evq[0].kind == K_OPT) void'(evq.pop_front());
    chk("t6_nvalid", n_valid, 0);
    chk("t6_at_most_one", (n_eof + n_err <= 1) ? 1 : 0, 1);
    chk("t6_cardet", mif.cardet, 0);
    expect_ev(K_VALID, 8'h55);
    expect_ev(K_VALID, 8'hC3);
    expect_ev(K_EOF, 8'h00);
    send_byte(8'h55, CELL, CELL);
    send_byte(8'hC3, CELL, CELL);
    idle(2);
    drain("t6_drain", 4 * CELL);
    chk("t6_last_byte", last_byte, 8'hC3);
    chk("t6_nvalid_after", n_valid, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
